// File: rtl/xfifo_axis_wr.sv
// AXI-Stream to FIFO write adapter: a 2-entry skid buffer decouples s_axis_tready
// from fifo_full, with a write-beat counter and a saturating write-error counter.
module xfifo_axis_wr #(
   parameter int AXIS_DATA_WIDTH = 32
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic                       fifo_wren,
   output logic [AXIS_DATA_WIDTH-1:0] fifo_di,
   input  logic                       fifo_full,
   input  logic                       fifo_wrerr,
   output logic [31:0]                beat_count,
   output logic [15:0]                wrerr_count
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_t;

   state_t                     r_state;
   logic [AXIS_DATA_WIDTH-1:0] r_head;
   logic [AXIS_DATA_WIDTH-1:0] r_tail;
   logic                       r_rdy_en;
   logic [31:0]                r_beat_count;
   logic [15:0]                r_wrerr_count;

   logic                       w_acc;
   logic                       w_wr;

   // tready depends on registers only, so fifo_full never reaches it combinationally
   assign s_axis_tready = r_rdy_en && (r_state != TWO);
   assign w_wr          = (r_state != EMPTY) && !fifo_full;
   assign w_acc         = s_axis_tvalid && s_axis_tready;

   assign fifo_wren   = w_wr;
   assign fifo_di     = r_head;
   assign beat_count  = r_beat_count;
   assign wrerr_count = r_wrerr_count;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state  <= EMPTY;
         r_head   <= '0;
         r_tail   <= '0;
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         case (r_state)
            EMPTY: begin
               if (w_acc) begin
                  r_head  <= s_axis_tdata;
                  r_state <= ONE;
               end
            end
            ONE: begin
               if (w_acc && !w_wr) begin
                  r_tail  <= s_axis_tdata;
                  r_state <= TWO;
               end else if (w_acc && w_wr) begin
                  r_head  <= s_axis_tdata;
               end else if (w_wr) begin
                  r_state <= EMPTY;
               end
            end
            TWO: begin
               if (w_wr) begin
                  r_head  <= r_tail;
                  r_state <= ONE;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_beat_count  <= '0;
         r_wrerr_count <= '0;
      end else begin
         if (w_wr) begin
            r_beat_count <= r_beat_count + 32'd1;
         end
         if (fifo_wrerr && (r_wrerr_count != 16'hFFFF)) begin
            r_wrerr_count <= r_wrerr_count + 16'd1;
         end
      end
   end

endmodule
